axis_bram_capture: RTL and testbench

- Pre/post-trigger capture stage that fills the dual-port BRAM that the AXI4-Lite BRAM reader later drains over port A.
- Accepts an AXI4-Stream of samples and writes them circularly into BRAM port B.
- Holds a programmable number of pre-trigger samples, then fills the rest of the buffer after a trigger.
- Freezes the buffer and reports the trigger address so software can unroll the ring.

---
 rtl/axis_bram_capture.sv | 121 ++++++++++++
 tb/tb_axis_bram_capture.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/axis_bram_capture.sv
// Pre/post-trigger capture: writes an AXI4-Stream circularly into BRAM port B,
// then freezes the ring once the post-trigger portion is full.
module axis_bram_capture #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int BRAM_DATA_WIDTH  = 32,
    parameter int BRAM_ADDR_WIDTH  = 10
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic [BRAM_ADDR_WIDTH-1:0]   cfg_pre,
    input  logic                         arm,
    input  logic                         trigger,
    output logic [2:0]                   sts_state,
    output logic                         sts_done,
    output logic [BRAM_ADDR_WIDTH-1:0]   sts_trig_addr,
    input  logic [AXIS_TDATA_WIDTH-1:0]  s_axis_tdata,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    output logic                         bram_portb_clk,
    output logic                         bram_portb_rst,
    output logic [BRAM_ADDR_WIDTH-1:0]   bram_portb_addr,
    output logic [BRAM_DATA_WIDTH-1:0]   bram_portb_wrdata,
    output logic [BRAM_DATA_WIDTH/8-1:0] bram_portb_we
);

    localparam int WE_WIDTH = BRAM_DATA_WIDTH / 8;
    localparam logic [BRAM_ADDR_WIDTH:0] DEPTH_WORDS =
        (BRAM_ADDR_WIDTH+1)'(1) << BRAM_ADDR_WIDTH;
    localparam logic [BRAM_ADDR_WIDTH:0] ONE_POST = (BRAM_ADDR_WIDTH+1)'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        ARMED = 3'd2,
        POST  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                     state;
    logic [BRAM_ADDR_WIDTH-1:0] wr_ptr;
    logic [BRAM_ADDR_WIDTH-1:0] pre_cnt;
    logic [BRAM_ADDR_WIDTH-1:0] p_reg;
    logic [BRAM_ADDR_WIDTH:0]   post_cnt;
    logic [BRAM_ADDR_WIDTH-1:0] trig_addr;

    logic                       wr_en;
    logic [BRAM_ADDR_WIDTH-1:0] pre_next;
    logic [BRAM_ADDR_WIDTH:0]   post_next;
    logic [BRAM_ADDR_WIDTH:0]   post_target;

    // An arm cycle never writes, so the restarted capture begins cleanly at address 0.
    always_comb begin
        wr_en = 1'b0;
        if (s_axis_tvalid && !arm &&
            (state == PRE || state == ARMED || state == POST))
            wr_en = 1'b1;
    end

    assign pre_next    = pre_cnt + 1'b1;
    assign post_next   = post_cnt + 1'b1;
    assign post_target = DEPTH_WORDS - {1'b0, p_reg};

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            pre_cnt   <= '0;
            p_reg     <= '0;
            post_cnt  <= '0;
            trig_addr <= '0;
        end else if (arm) begin
            wr_ptr   <= '0;
            pre_cnt  <= '0;
            post_cnt <= '0;
            p_reg    <= cfg_pre;
            state    <= (cfg_pre == '0) ? ARMED : PRE;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            case (state)
                PRE: begin
                    if (wr_en) begin
                        pre_cnt <= pre_next;
                        if (pre_next == p_reg)
                            state <= ARMED;
                    end
                end
                ARMED: begin
                    // The beat coinciding with the trigger is post sample 1.
                    if (trigger) begin
                        trig_addr <= wr_ptr;
                        post_cnt  <= wr_en ? ONE_POST : '0;
                        if (wr_en && post_target == ONE_POST)
                            state <= DONE;
                        else
                            state <= POST;
                    end
                end
                POST: begin
                    if (wr_en) begin
                        post_cnt <= post_next;
                        if (post_next == post_target)
                            state <= DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sts_state         = state;
    assign sts_done          = (state == DONE);
    assign sts_trig_addr     = trig_addr;
    assign s_axis_tready     = 1'b1;
    assign bram_portb_clk    = aclk;
    assign bram_portb_rst    = areset;
    assign bram_portb_addr   = wr_ptr;
    assign bram_portb_wrdata = s_axis_tdata;
    assign bram_portb_we     = {WE_WIDTH{wr_en}};

endmodule

// File: tb/tb_axis_bram_capture.sv
// Directed bench for axis_bram_capture on a 16-word ring with a shadow BRAM.
module tb_axis_bram_capture;

    localparam int AW = 4;
    localparam int DW = 32;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic [AW-1:0] cfg_pre = '0;
    logic          arm = 1'b0;
    logic          trigger = 1'b0;
    logic [2:0]    sts_state;
    logic          sts_done;
    logic [AW-1:0] sts_trig_addr;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          bram_portb_clk;
    logic          bram_portb_rst;
    logic [AW-1:0] bram_portb_addr;
    logic [DW-1:0] bram_portb_wrdata;
    logic [DW/8-1:0] bram_portb_we;

    logic [DW-1:0] mem [16];
    logic [3:0]    obsWe;
    logic [AW-1:0] obsAddr;
    int            checks = 0;
    int            failures = 0;

    axis_bram_capture #(
        .AXIS_TDATA_WIDTH(DW),
        .BRAM_DATA_WIDTH(DW),
        .BRAM_ADDR_WIDTH(AW)
    ) dut (
        .aclk(aclk),
        .areset(areset),
        .cfg_pre(cfg_pre),
        .arm(arm),
        .trigger(trigger),
        .sts_state(sts_state),
        .sts_done(sts_done),
        .sts_trig_addr(sts_trig_addr),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .bram_portb_clk(bram_portb_clk),
        .bram_portb_rst(bram_portb_rst),
        .bram_portb_addr(bram_portb_addr),
        .bram_portb_wrdata(bram_portb_wrdata),
        .bram_portb_we(bram_portb_we)
    );

    always #5 aclk = ~aclk;

    // Shadow BRAM fed only by the port-B write interface.
    always @(posedge aclk) begin
        if (bram_portb_we == 4'hF)
            mem[bram_portb_addr] <= bram_portb_wrdata;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One cycle: inputs set at negedge, write port captured mid-cycle, then clocked.
    task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic a, input logic t);
        @(negedge aclk);
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        arm           = a;
        trigger       = t;
        #1;
        obsWe   = bram_portb_we;
        obsAddr = bram_portb_addr;
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
        arm           = 1'b0;
        trigger       = 1'b0;
    endtask

    task automatic beat(input logic [DW-1:0] d, input logic [AW-1:0] expAddr, input string tag);
        applyStimulus(1'b1, d, 1'b0, 1'b0);
        checkOutput({tag, "_we"}, 32'(obsWe), 32'hF);
        checkOutput({tag, "_addr"}, 32'(obsAddr), 32'(expAddr));
    endtask

    initial begin
        // Reset with the stream running
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 32'(i);
            #1;
            checkOutput("reset_we", 32'(bram_portb_we), 0);
        end
        checkOutput("reset_state", 32'(sts_state), 0);
        checkOutput("reset_done", 32'(sts_done), 0);
        checkOutput("reset_trig", 32'(sts_trig_addr), 0);
        checkOutput("tready", 32'(s_axis_tready), 1);
        @(negedge aclk);
        areset = 1'b0;
        for (int i = 3; i < 6; i++) begin
            applyStimulus(1'b1, 32'(i), 1'b0, 1'b0);
            checkOutput("idle_we", 32'(obsWe), 0);
            checkOutput("idle_state", 32'(sts_state), 0);
        end

        // Pre-trigger fill of 4 words, with an ignored trigger in PRE
        cfg_pre = 4'd4;
        applyStimulus(1'b1, 32'd99, 1'b1, 1'b0);
        checkOutput("arm_we", 32'(obsWe), 0);
        checkOutput("arm_state", 32'(sts_state), 1);
        cfg_pre = 4'd9;
        beat(100, 0, "pre0");
        beat(101, 1, "pre1");
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
        checkOutput("pre_trig_ignored", 32'(sts_state), 1);
        beat(102, 2, "pre2");
        checkOutput("pre_still", 32'(sts_state), 1);
        beat(103, 3, "pre3");
        checkOutput("armed_state", 32'(sts_state), 2);

        // Armed beats, then trigger coincident with a beat
        for (int i = 0; i < 6; i++) beat(32'(104 + i), AW'(4 + i), "armed");
        checkOutput("armed_hold", 32'(sts_state), 2);
        applyStimulus(1'b1, 32'd110, 1'b0, 1'b1);
        checkOutput("trig_we", 32'(obsWe), 32'hF);
        checkOutput("trig_addr_wr", 32'(obsAddr), 10);
        checkOutput("post_state", 32'(sts_state), 3);
        checkOutput("trig_addr", 32'(sts_trig_addr), 10);
        for (int i = 1; i < 11; i++) beat(32'(110 + i), AW'(10 + i), "post");
        checkOutput("post_before_last", 32'(sts_state), 3);
        beat(121, 5, "post_last");
        checkOutput("done_state", 32'(sts_state), 4);
        checkOutput("done_flag", 32'(sts_done), 1);
        for (int i = 6; i < 10; i++) checkOutput("mem_pre", mem[i], 32'(100 + i));
        checkOutput("mem10", mem[10], 110);
        checkOutput("mem0", mem[0], 116);
        checkOutput("mem5", mem[5], 121);
        applyStimulus(1'b1, 32'd999, 1'b0, 1'b0);
        checkOutput("done_we", 32'(obsWe), 0);
        checkOutput("done_hold", 32'(sts_state), 4);

        // Zero pre-trigger: full ring of post samples
        cfg_pre = 4'd0;
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        checkOutput("arm0_state", 32'(sts_state), 2);
        checkOutput("arm0_done", 32'(sts_done), 0);
        applyStimulus(1'b1, 32'd200, 1'b0, 1'b1);
        checkOutput("trig0_addr_wr", 32'(obsAddr), 0);
        checkOutput("trig0_state", 32'(sts_state), 3);
        checkOutput("trig0_addr", 32'(sts_trig_addr), 0);
        for (int i = 1; i < 15; i++) beat(32'(200 + i), AW'(i), "post0");
        checkOutput("post0_before_last", 32'(sts_state), 3);
        beat(215, 15, "post0_last");
        checkOutput("done0_state", 32'(sts_state), 4);
        checkOutput("mem0_0", mem[0], 200);
        checkOutput("mem0_15", mem[15], 215);

        // Arm and trigger together during POST: arm wins
        cfg_pre = 4'd2;
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        beat(300, 0, "r0");
        beat(301, 1, "r1");
        checkOutput("r_armed", 32'(sts_state), 2);
        applyStimulus(1'b1, 32'd302, 1'b0, 1'b1);
        checkOutput("r_post", 32'(sts_state), 3);
        checkOutput("r_trig_addr", 32'(sts_trig_addr), 2);
        beat(303, 3, "r3");
        applyStimulus(1'b1, 32'd777, 1'b1, 1'b1);
        checkOutput("rearm_we", 32'(obsWe), 0);
        checkOutput("rearm_state", 32'(sts_state), 1);
        checkOutput("rearm_done", 32'(sts_done), 0);
        checkOutput("rearm_trig_held", 32'(sts_trig_addr), 2);
        beat(304, 0, "rearm0");
        beat(305, 1, "rearm1");
        beat(306, 2, "rearm2");
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
        checkOutput("nobeat_trig_state", 32'(sts_state), 3);
        checkOutput("nobeat_trig_addr", 32'(sts_trig_addr), 3);
        beat(307, 3, "post_r");

        // Asynchronous reset in the middle of a POST beat
        @(negedge aclk);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'd308;
        #1;
        checkOutput("prereset_we", 32'(bram_portb_we), 32'hF);
        areset = 1'b1;
        #1;
        checkOutput("async_we", 32'(bram_portb_we), 0);
        checkOutput("async_state", 32'(sts_state), 0);
        checkOutput("async_trig", 32'(sts_trig_addr), 0);
        @(negedge aclk);
        areset = 1'b0;
        s_axis_tvalid = 1'b0;
        cfg_pre = 4'd3;
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        checkOutput("restart_state", 32'(sts_state), 1);
        beat(400, 0, "restart0");
        beat(401, 1, "restart1");
        checkOutput("mem_restart", mem[0], 400);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
